alu_muldiv: RTL and testbench

Parametrised integer execution unit for the pipelined MIPS datapath, replacing the fixed 32-bit combinational ALU in the EX stage. Logic, add/sub and set-less-than ops resolve combinationally in the same cycle. MULT/MULTU/DIV/DIVU run as iterative multi-cycle operations with a start/busy/done handshake and write the architectural HI/LO registers. The hazard unit stalls the pipeline on `busy`.

---
 rtl/alu_muldiv.sv | 196 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Integer execution unit: single-cycle logic/arith/compare ops plus iterative
// multiply/divide writing the architectural HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;
  localparam logic [3:0] OP_MFLO = 4'd13;
  localparam logic [3:0] OP_MTHI = 4'd14;
  localparam logic [3:0] OP_MTLO = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] a_orig;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             div_zero;

  // Subtract-based ops share one adder; SLT/SLTU derive their flags from it.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             slt_flag;
  logic             sltu_flag;

  assign is_sub    = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  assign b_eff     = is_sub ? ~b : b;
  assign sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign slt_flag  = sum[WIDTH-1] ^ add_ovf;
  assign sltu_flag = ~sum[WIDTH];

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  begin result = sum[WIDTH-1:0]; ovf = add_ovf; end
      OP_SLT:  result = WIDTH'(slt_flag);
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SUB:  begin result = sum[WIDTH-1:0]; ovf = add_ovf; end
      OP_SLTU: result = WIDTH'(sltu_flag);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign busy = (state != IDLE);

  logic             md_op;
  logic             signed_op;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign md_op     = (op == OP_MULT) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // One iteration step: shift-add for multiply, restoring step for divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_r;
  logic [WIDTH-1:0] div_d;
  logic             div_ge;

  assign mul_sum = {1'b0, acc} + {1'b0, (low[0] ? mcand : {WIDTH{1'b0}})};
  assign div_r   = {acc, low[WIDTH-1]};
  assign div_ge  = (div_r >= {1'b0, mcand});
  assign div_d   = div_r[WIDTH-1:0] - mcand;

  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_raw = {acc, low};
  assign prod_fix = neg_lo ? -prod_raw : prod_raw;
  assign quo_fix  = neg_lo ? -low : low;
  assign rem_fix  = neg_hi ? -acc : acc;

  // Both operand orders use low as the shifting register and mcand as the addend/divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      low      <= '0;
      mcand    <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (md_op) begin
              state    <= RUN;
              cnt      <= '0;
              acc      <= '0;
              low      <= mag_a;
              mcand    <= mag_b;
              a_orig   <= a;
              is_div   <= op[1];
              neg_lo   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi   <= signed_op && op[1] && a[WIDTH-1];
              div_zero <= op[1] && (b == '0);
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (cnt == CW'(WIDTH)) begin
            state <= DONE;
            done  <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
              acc <= div_ge ? div_d : div_r[WIDTH-1:0];
              low <= {low[WIDTH-2:0], div_ge};
            end else begin
              acc <= mul_sum[WIDTH:1];
              low <= {mul_sum[0], low[WIDTH-1:1]};
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed and random ops against an
// arithmetic reference model, on a 32-bit and an 8-bit instance.
module tb_alu_muldiv;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, result, hi, lo;
  logic [3:0]  op;
  logic        start, zero, ovf, busy, done;

  logic [7:0]  a8, b8, result8, hi8, lo8;
  logic [3:0]  op8;
  logic        start8, zero8, ovf8, busy8, done8;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mh, ml;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
    .result(result), .zero(zero), .ovf(ovf), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .op(op8), .start(start8),
    .result(result8), .zero(zero8), .ovf(ovf8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8)
  );

  function automatic logic [31:0] model_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4:  return x ^ y;
      4'd5:  return ~(x | y);
      4'd6:  return x - y;
      4'd7:  return (x < y) ? 32'd1 : 32'd0;
      4'd12: return mh;
      4'd13: return ml;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint s  = (o == 4'd2) ? sx + sy : sx - sy;
    return ((o == 4'd2) || (o == 4'd6)) && ((s > 64'sd2147483647) || (s < -64'sd2147483648));
  endfunction

  // Returns {hi, lo} for a mul/div op.
  function automatic logic [63:0] model_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint q, r;
    if (o == 4'd8) return 64'(sx * sy);
    if (o == 4'd9) return {32'd0, x} * {32'd0, y};
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 4'd10) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'd0;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic s);
    op = o; a = x; b = y; start = s;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb_check(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] er, input logic ez, input logic eo);
    applyStimulus(o, x, y, 1'b0);
    #1;
    checkOutput({tag, ".result"}, 64'(result), 64'(er));
    checkOutput({tag, ".zero"}, 64'(zero), 64'(ez));
    checkOutput({tag, ".ovf"}, 64'(ovf), 64'(eo));
  endtask

  // Waits for done with a cycle budget; k counts edges since the start edge.
  task automatic wait_done(inout int k);
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic md_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el);
    int k;
    applyStimulus(o, x, y, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
    checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
    k = 0;
    @(posedge clk); #1;
    k = 1;
    wait_done(k);
    checkOutput({tag, ".latency"}, 64'(k), 64'(W + 1));
    mh = eh;
    ml = el;
    op = 4'd13;
    #1;
    checkOutput({tag, ".mflo"}, 64'(result), 64'(el));
    checkOutput({tag, ".hi"}, 64'(hi), 64'(eh));
    checkOutput({tag, ".lo"}, 64'(lo), 64'(el));
    @(posedge clk); #1;
    checkOutput({tag, ".idle"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] e;
    logic [3:0]  o;
    logic [31:0] x, y;
    int          k;

    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    a8 = 8'd0; b8 = 8'd0; op8 = 4'd0; start8 = 1'b0;
    mh = 32'd0; ml = 32'd0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset.state", 64'({busy, done}), 64'd0);
    checkOutput("reset.hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    comb_check("add", 4'd2, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0);
    comb_check("sub", 4'd6, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    comb_check("slt", 4'd3, 32'd5, 32'd7, 32'd1, 1'b0, 1'b0);
    comb_check("slt.neg", 4'd3, 32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0);
    comb_check("sltu", 4'd7, 32'd5, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    comb_check("add.ovf", 4'd2, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);
    comb_check("sub.zero", 4'd6, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 7));
      x = pick();
      y = pick();
      comb_check("rand.comb", o, x, y, model_res(o, x, y), model_res(o, x, y) == 32'd0, model_ovf(o, x, y));
    end

    md_op("mult", 4'd8, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md_op("multu", 4'd9, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
    md_op("div", 4'd10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_op("divu", 4'd11, 32'd7, 32'd2, 32'd1, 32'd3);
    md_op("div.minneg", 4'd10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    md_op("divu.zero", 4'd11, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
    md_op("div.zero", 4'd10, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF);

    applyStimulus(4'd14, 32'hCAFE0001, 32'd0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd12, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("mthi.mfhi", 64'(result), 64'h0000_0000_CAFE_0001);
    mh = 32'hCAFE0001;
    applyStimulus(4'd15, 32'h0BADF00D, 32'd0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd13, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("mtlo.mflo", 64'(result), 64'h0000_0000_0BAD_F00D);
    ml = 32'h0BADF00D;

    // MTHI attempted while busy must not disturb the product.
    applyStimulus(4'd9, 32'h00010000, 32'h00030000, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    applyStimulus(4'd14, 32'hDEADBEEF, 32'd0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    k = 5;
    wait_done(k);
    checkOutput("mthi.busy.latency", 64'(k), 64'(W + 1));
    checkOutput("mthi.busy.hilo", {hi, lo}, 64'h0000_0003_0000_0000);
    mh = 32'd3; ml = 32'd0;
    @(posedge clk); #1;

    // start held through the DONE cycle: only one op may run.
    applyStimulus(4'd9, 32'd3, 32'd5, 1'b1);
    @(posedge clk); #1;
    k = 0;
    wait_done(k);
    checkOutput("held.lo", 64'(lo), 64'd15);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("held.idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    checkOutput("held.still.idle", 64'(busy), 64'd0);
    mh = 32'd0; ml = 32'd15;

    md_op("b2b.first", 4'd9, 32'd6, 32'd7, 32'd0, 32'd42);
    md_op("b2b.second", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);

    for (int i = 0; i < 8; i++) begin
      o = 4'(8 + $urandom_range(0, 3));
      x = pick();
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : pick();
      e = model_md(o, x, y);
      md_op("rand.md", o, x, y, e[63:32], e[31:0]);
    end

    // Reset in the middle of a divide clears everything immediately.
    applyStimulus(4'd15, 32'hAA, 32'd0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(4'd13, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("rst.mtlo", 64'(result), 64'hAA);
    applyStimulus(4'd10, 32'd100, 32'd7, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checkOutput("rst.mid.state", 64'({busy, done}), 64'd0);
    checkOutput("rst.mid.hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mh = 32'd0; ml = 32'd0;
    applyStimulus(4'd13, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("rst.mflo", 64'(result), 64'd0);
    md_op("rst.mult", 4'd8, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);

    a8 = 8'hFF; b8 = 8'hFF; op8 = 4'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("w8.latency", 64'(k), 64'd9);
    checkOutput("w8.hilo", 64'({hi8, lo8}), 64'hFE01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
